clk8_edge_timer: RTL and testbench

CLK8_EDGE_TIMER -- requirements
Module: clk8_edge_timer

---
 rtl/clk8_timer_pkg.sv | 14 +
 rtl/clk8_edge_timer_rise_det.sv | 28 ++
 rtl/clk8_edge_timer.sv | 107 ++++++++++
 tb/tb_clk8_edge_timer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk8_timer_pkg.sv
// Shared definitions for the clk_8 edge timer.
// Holds the FSM state encoding and the default widths used by
// clk8_edge_timer (terminal-count width and edge-counter width).
package clk8_timer_pkg;

  localparam int TC_W_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/clk8_edge_timer_rise_det.sv
// Rising-edge detector for a level that is already synchronous to clk.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   din   - input level
//   rise  - high for the cycle in which din is 1 and was 0 last cycle
// The delayed copy resets to 0, so a level already high when reset is
// released registers as one rise on the first cycle.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_d <= 1'b0;
    end else begin
      din_d <= din;
    end
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/clk8_edge_timer.sv
// Timer that counts rising edges of the divide-by-8 clock level clk_8
// and emits a tick after every tc edges.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   clk_8    - divide-by-8 level, synchronous to clk
//   start    - one-cycle pulse, arms or restarts the timer (ignored if tc == 0)
//   stop     - one-cycle pulse, halts the timer; wins over start
//   tc       - clk_8 edges per tick, captured on an accepted start
//   tick     - one-cycle pulse after the terminal edge of each period
//   busy     - high while running
//   edge_cnt - clk_8 edges since the last accepted start, saturating
//   ovf      - sticky, set when edge_cnt reaches all-ones
module clk8_edge_timer
  import clk8_timer_pkg::*;
#(
  parameter int TC_W  = TC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_8,
  input  logic             start,
  input  logic             stop,
  input  logic [TC_W-1:0]  tc,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nx;
  logic              rise;
  logic              accept;
  logic              last_edge;
  logic [TC_W-1:0]   tc_q;
  logic [TC_W-1:0]   pcnt;

  rise_det u_rise_det (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (clk_8),
    .rise  (rise)
  );

  // A start is only honoured with a non-zero period and no competing stop.
  always_comb begin
    accept    = start && !stop && (tc != '0);
    last_edge = (pcnt == tc_q - TC_W'(1));
    state_nx  = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (stop)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
    end
  end

  // Period counter, edge counter and tick. tick defaults low every cycle
  // so it can never stretch beyond one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q     <= '0;
      pcnt     <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (state == RUN && stop) begin
        // Halt: drop the partial period, keep the edge count and flag.
        pcnt <= '0;
      end else if (accept) begin
        // Arm or restart; a rise in this same cycle is deliberately lost.
        tc_q     <= tc;
        pcnt     <= '0;
        edge_cnt <= '0;
        ovf      <= 1'b0;
      end else if (state == RUN && rise) begin
        if (last_edge) begin
          pcnt <= '0;
          tick <= 1'b1;
        end else begin
          pcnt <= pcnt + TC_W'(1);
        end
        if (edge_cnt != CNT_MAX) begin
          edge_cnt <= edge_cnt + CNT_W'(1);
        end
        if (edge_cnt >= CNT_MAX - CNT_W'(1)) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk8_edge_timer.sv
// Directed bench for clk8_edge_timer. Two instances share the stimulus:
// one with the default 16-bit edge counter, one with a 4-bit counter to
// reach saturation quickly. clk_8 comes from a divide-by-8 counter on clk
// that is reset together with the timers, so edge timing is fixed:
// counting the clk rising edges after reset release as P1, P2, ...,
// clk_8 rises are sampled by the timer at P5, P13, P21, ... (P5 + 8k).
module tb_clk8_edge_timer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [7:0]  tc;
  logic [2:0]  div;
  logic        clk_8;

  logic        tick16, busy16, ovf16;
  logic [15:0] edge16;
  logic        tick4, busy4, ovf4;
  logic [3:0]  edge4;

  int n_cmp;
  int n_err;
  int n_tick;
  int n_busy;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Upstream divide-by-8: clk_8 is the counter MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= 3'd0;
    else        div <= div + 3'd1;
  end
  assign clk_8 = div[2];

  clk8_edge_timer #(.TC_W(8), .CNT_W(16)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_8    (clk_8),
    .start    (start),
    .stop     (stop),
    .tc       (tc),
    .tick     (tick16),
    .busy     (busy16),
    .edge_cnt (edge16),
    .ovf      (ovf16)
  );

  clk8_edge_timer #(.TC_W(8), .CNT_W(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_8    (clk_8),
    .start    (start),
    .stop     (stop),
    .tc       (tc),
    .tick     (tick4),
    .busy     (busy4),
    .edge_cnt (edge4),
    .ovf      (ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset for 100 ns, check outputs while held, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst busy16", busy16, 0);
    chk("rst tick16", tick16, 0);
    chk("rst edge16", edge16, 0);
    chk("rst ovf16",  ovf16,  0);
    chk("rst busy4",  busy4,  0);
    chk("rst edge4",  edge4,  0);
    rst_n = 1'b1;
  endtask

  task automatic arm(input logic [7:0] t);
    step(1);
    tc    = t;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tc    = 8'd0;

    // Basic run, tc=4: ticks after P29 and P61; tc change mid-run ignored.
    do_reset();
    arm(8'd4);
    tc = 8'd9;
    chk("A busy",       busy16, 1);
    chk("A cnt start",  edge16, 0);
    chk("A tick start", tick16, 0);
    step(26);
    chk("A pre-tick",   tick16, 0);
    chk("A cnt3",       edge16, 3);
    step(1);
    chk("A tick1",      tick16, 1);
    chk("A cnt4",       edge16, 4);
    step(1);
    chk("A tick width", tick16, 0);
    step(30);
    chk("A gap",        tick16, 0);
    step(1);
    chk("A tick2",      tick16, 1);
    chk("A cnt8",       edge16, 8);
    chk("A tick2 w4",   tick4,  1);
    chk("A cnt8 w4",    edge4,  8);
    chk("A ovf w4",     ovf4,   0);

    // Stop sampled together with the terminal rise: no tick, count held.
    do_reset();
    arm(8'd4);
    step(26);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("B1 tick supp", tick16, 0);
    chk("B1 busy",      busy16, 0);
    chk("B1 cnt hold",  edge16, 3);
    step(1);
    chk("B1 no tick",   tick16, 0);

    // Stop after 6 edges.
    do_reset();
    arm(8'd4);
    step(43);
    chk("B2 busy run",  busy16, 1);
    chk("B2 cnt6",      edge16, 6);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("B2 busy off",  busy16, 0);
    chk("B2 cnt hold",  edge16, 6);
    step(15);
    chk("B2 no tick",   tick16, 0);
    chk("B2 cnt still", edge16, 6);
    chk("B2 idle",      busy16, 0);

    // IDLE: start+stop together, then start with tc=0; nothing changes.
    tc    = 8'd4;
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("C ss busy",    busy16, 0);
    chk("C ss cnt",     edge16, 6);
    tc    = 8'd0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("C tc0 busy",   busy16, 0);
    chk("C tc0 cnt",    edge16, 6);
    step(1);
    chk("C tc0 busy2",  busy16, 0);
    chk("C tc0 tick",   tick16, 0);

    // Saturation on the 4-bit counter, tc=3: ticks every 24 cycles.
    do_reset();
    arm(8'd3);
    step(19);
    chk("D tick P21",   tick4, 1);
    chk("D cnt3",       edge4, 3);
    step(95);
    chk("D cnt14",      edge4, 14);
    chk("D ovf pre",    ovf4,  0);
    step(1);
    chk("D cnt15",      edge4, 15);
    chk("D ovf set",    ovf4,  1);
    chk("D tick P117",  tick4, 1);
    step(8);
    chk("D cnt sat",    edge4, 15);
    chk("D ovf sticky", ovf4,  1);
    chk("D cnt16 w16",  edge16, 16);
    step(16);
    chk("D tick P141",  tick4, 1);
    chk("D ovf still",  ovf4,  1);
    chk("D cnt18 w16",  edge16, 18);
    chk("D ovf w16",    ovf16, 0);
    // Restart in RUN on the same cycle as a rise (P149): rise not counted.
    step(7);
    tc    = 8'd3;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("D rs cnt",     edge4, 0);
    chk("D rs ovf",     ovf4,  0);
    chk("D rs busy",    busy4, 1);
    chk("D rs cnt w16", edge16, 0);
    chk("D rs tick",    tick4, 0);
    step(23);
    chk("D rs pre",     tick4, 0);
    chk("D rs cnt2",    edge4, 2);
    step(1);
    chk("D rs tick1",   tick4, 1);
    chk("D rs cnt3",    edge4, 3);

    // Asynchronous reset mid-period (after 2 edges).
    do_reset();
    arm(8'd4);
    step(11);
    chk("E cnt2",       edge16, 2);
    chk("E busy",       busy16, 1);
    #4;
    rst_n = 1'b0;
    #1;
    chk("E busy async", busy16, 0);
    chk("E cnt async",  edge16, 0);
    chk("E tick async", tick16, 0);
    chk("E ovf async",  ovf16,  0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    n_tick = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (tick16 || tick4) n_tick++;
      if (busy16 || busy4) n_busy++;
    end
    chk("E no tick",    n_tick, 0);
    chk("E stay idle",  n_busy, 0);
    chk("E cnt idle",   edge16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
